// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory bus and the fetch/decode handshake of instr_fetch_unit.
// master = fetch unit side, slave = memory plus decoder/datapath side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  OP;
    logic [5:0]  Funct;
    logic        instr_valid;
    logic        instr_ready;
    logic        Branch;
    logic        Zero;
    logic        Jump;

    modport master (
        output imem_req, imem_addr, instr, OP, Funct, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, Branch, Zero, Jump
    );

    modport slave (
        input  imem_req, imem_addr, instr, OP, Funct, instr_valid,
        output imem_ack, imem_rdata, instr_ready, Branch, Zero, Jump
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the MIPS-subset core: PC register, imem req/ack fetch, next-PC selection.
// Optional retired-instruction counter built only when FETCH_RETIRE_COUNT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        bus,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic                      fetch_err,
    output logic [31:0]               retired_count
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  tmo_cnt, tmo_cnt_nxt;
    logic [31:0] instr_q;
    logic [31:0] next_pc;
    logic        req, valid, load_instr, fire, err_set;

    // Jump beats Branch; branch offset is the sign-extended word displacement from pc+4.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] pp4,
        input logic [31:0] ins,
        input logic        br,
        input logic        zr,
        input logic        jp
    );
        logic signed [31:0] offs;
        offs = {{14{ins[15]}}, ins[15:0], 2'b00};
        if (jp)
            return {pp4[31:28], ins[25:0], 2'b00};
        else if (br && zr)
            return pp4 + $unsigned(offs);
        else
            return pp4;
    endfunction

    assign pc_plus4 = pc + 32'd4;
    assign next_pc  = calc_next_pc(pc_plus4, instr_q, bus.Branch, bus.Zero, bus.Jump);

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        req         = 1'b0;
        valid       = 1'b0;
        load_instr  = 1'b0;
        fire        = 1'b0;
        err_set     = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    load_instr  = 1'b1;
                    tmo_cnt_nxt = 8'd0;
                    state_nxt   = HOLD;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_set     = 1'b1;
                    tmo_cnt_nxt = 8'd0;
                    state_nxt   = ERROR;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            HOLD: begin
                valid = 1'b1;
                if (bus.instr_ready) begin
                    fire      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            ERROR: state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= 8'd0;
            pc        <= RESET_PC;
            instr_q   <= 32'h0;
            fetch_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (load_instr)
                instr_q <= bus.imem_rdata;
            if (fire)
                pc <= next_pc;
            if (err_set)
                fetch_err <= 1'b1;
        end
    end

    // Request/valid are pure state decodes, so they fall the cycle the state leaves.
    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid;
    assign bus.instr       = instr_q;
    assign bus.OP          = instr_q[31:26];
    assign bus.Funct       = instr_q[5:0];

`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0] ret_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ret_cnt <= 32'h0;
        else if (fire)
            ret_cnt <= ret_cnt + 32'd1;
    end

    assign retired_count = ret_cnt;
`else
    assign retired_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of fetch transactions plus reset/timeout sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, pc_plus4, retired_count;
    logic        fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit_if bus_if();

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_if),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_err     (fetch_err),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ack_dly;
        logic [31:0] rdata;
        logic        br;
        logic        zr;
        logic        jp;
        int          rdy_dly;
        logic [31:0] addr;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [31:0] exp_ret(input int n);
`ifdef FETCH_RETIRE_COUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name, input int budget);
        int k;
        k = 0;
        while (bus_if.imem_req !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus_if.imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL %s: no imem_req within %0d cycles", name, budget);
        end
    endtask

    // Called at a negedge in the first FETCH cycle; returns at the first FETCH cycle of the next fetch.
    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, "_req"}, 32'(bus_if.imem_req), 32'd1);
        chk({p, "_addr"}, bus_if.imem_addr, v.addr);
        repeat (v.ack_dly) begin
            @(negedge clk);
            chk({p, "_req_wait"}, 32'(bus_if.imem_req), 32'd1);
            chk({p, "_addr_wait"}, bus_if.imem_addr, v.addr);
        end
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = v.rdata;
        @(negedge clk);
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        chk({p, "_valid"}, 32'(bus_if.instr_valid), 32'd1);
        chk({p, "_instr"}, bus_if.instr, v.rdata);
        chk({p, "_op"}, 32'(bus_if.OP), 32'(v.rdata[31:26]));
        chk({p, "_funct"}, 32'(bus_if.Funct), 32'(v.rdata[5:0]));
        chk({p, "_req_hold"}, 32'(bus_if.imem_req), 32'd0);
        chk({p, "_pc"}, pc, v.addr);
        chk({p, "_pc4"}, pc_plus4, v.addr + 32'd4);
        bus_if.Branch = v.br;
        bus_if.Zero   = v.zr;
        bus_if.Jump   = v.jp;
        repeat (v.rdy_dly) begin
            @(negedge clk);
            chk({p, "_stall_valid"}, 32'(bus_if.instr_valid), 32'd1);
            chk({p, "_stall_instr"}, bus_if.instr, v.rdata);
            chk({p, "_stall_req"}, 32'(bus_if.imem_req), 32'd0);
            chk({p, "_stall_pc"}, pc, v.addr);
        end
        bus_if.instr_ready = 1'b1;
        @(negedge clk);
        bus_if.instr_ready = 1'b0;
        bus_if.Branch = 1'b0;
        bus_if.Zero   = 1'b0;
        bus_if.Jump   = 1'b0;
        chk({p, "_valid_drop"}, 32'(bus_if.instr_valid), 32'd0);
        chk({p, "_next_req"}, 32'(bus_if.imem_req), 32'd1);
        chk({p, "_next_addr"}, bus_if.imem_addr, v.nxt);
    endtask

    initial begin
        tbl[0]  = '{0, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0000, 32'h0000_0004};
        tbl[1]  = '{1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5, 32'h0000_0004, 32'h0000_0008};
        tbl[2]  = '{0, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 0, 32'h0000_0008, 32'h0000_0004};
        tbl[3]  = '{2, 32'h1000_FFFD, 1'b1, 1'b1, 1'b0, 1, 32'h0000_0004, 32'hFFFF_FFFC};
        tbl[4]  = '{0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[5]  = '{3, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0000, 32'h0000_0004};
        tbl[6]  = '{0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 32'h0000_0004, 32'h0000_0008};
        tbl[7]  = '{1, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0008, 32'h0000_000C};
        tbl[8]  = '{0, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 0, 32'h0000_000C, 32'h0FFF_FFFC};
        tbl[9]  = '{0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 32'h0FFF_FFFC, 32'h1000_0000};
        tbl[10] = '{2, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 32'h1000_0000, 32'h1000_0100};
        tbl[11] = '{1, 32'h1000_0001, 1'b0, 1'b1, 1'b0, 0, 32'h1000_0100, 32'h1000_0104};

        rst_n              = 1'b0;
        bus_if.imem_ack    = 1'b0;
        bus_if.imem_rdata  = 32'h0;
        bus_if.instr_ready = 1'b0;
        bus_if.Branch      = 1'b0;
        bus_if.Zero        = 1'b0;
        bus_if.Jump        = 1'b0;

        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_instr", bus_if.instr, 32'h0);
        chk("rst_op", 32'(bus_if.OP), 32'h0);
        chk("rst_funct", 32'(bus_if.Funct), 32'h0);
        chk("rst_req", 32'(bus_if.imem_req), 32'd0);
        chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_ret", retired_count, 32'h0);

        // Release reset with a stray ack present during the IDLE cycle.
        rst_n             = 1'b1;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'hCAFE_F00D;
        #1;
        chk("idle_req", 32'(bus_if.imem_req), 32'd0);
        @(negedge clk);
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        chk("idle_ack_ignored", bus_if.instr, 32'h0);
        chk("first_fetch_req", 32'(bus_if.imem_req), 32'd1);

        for (int i = 0; i < 12; i++)
            run_vec(i, tbl[i]);

        chk("retired_after_tbl", retired_count, exp_ret(12));

        // No ack: 15 FETCH cycles, then ERROR.
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("tmo_req_%0d", i), 32'(bus_if.imem_req), 32'd1);
            chk($sformatf("tmo_err_%0d", i), 32'(fetch_err), 32'd0);
            @(negedge clk);
        end
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("err_req_%0d", i), 32'(bus_if.imem_req), 32'd0);
            chk($sformatf("err_flag_%0d", i), 32'(fetch_err), 32'd1);
            chk($sformatf("err_valid_%0d", i), 32'(bus_if.instr_valid), 32'd0);
            @(negedge clk);
        end
        bus_if.imem_ack   = 1'b0;
        chk("err_pc", pc, 32'h1000_0104);
        chk("err_instr", bus_if.instr, 32'h1000_0001);

        rst_n = 1'b0;
        #1;
        chk("err_rst_flag", 32'(fetch_err), 32'd0);
        chk("err_rst_pc", pc, 32'h0);
        chk("err_rst_instr", bus_if.instr, 32'h0);
        chk("err_rst_ret", retired_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("restart_req", 10);
        chk("restart_addr", bus_if.imem_addr, 32'h0);

        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        chk("restart_instr", bus_if.instr, 32'h1234_5678);
        bus_if.instr_ready = 1'b1;
        @(negedge clk);
        bus_if.instr_ready = 1'b0;
        chk("restart_next_addr", bus_if.imem_addr, 32'h4);
        chk("restart_ret", retired_count, exp_ret(1));

        // Reset mid-FETCH, then a late ack lands in IDLE.
        rst_n = 1'b0;
        #1;
        chk("midrst_instr", bus_if.instr, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_req", 32'(bus_if.imem_req), 32'd0);
        @(negedge clk);
        rst_n             = 1'b1;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        chk("late_ack_instr", bus_if.instr, 32'h0);
        chk("late_ack_pc", pc, 32'h0);
        chk("late_ack_req", 32'(bus_if.imem_req), 32'd1);
        chk("late_ack_valid", 32'(bus_if.instr_valid), 32'd0);
        @(negedge clk);
        chk("late_ack_instr2", bus_if.instr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the main control decoder in the MIPS-subset core. Holds the PC, requests instruction words from instruction memory over a req/ack handshake, and presents the latched instruction and its OP/Funct fields to the decoder and datapath. Computes the next PC from the Branch/Zero/Jump outcome returned by the downstream stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; must be a multiple of 4
ACK_TIMEOUT, 15, max cycles in FETCH without imem_ack before error; range 1..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction memory request
imem_addr  out  32  byte address of requested word (= pc)
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
instr  out  32  latched instruction
OP  out  6  instr[31:26], to control decoder
Funct  out  6  instr[5:0], to control decoder
instr_valid  out  1  instr/OP/Funct valid
instr_ready  in  1  downstream consumes instr this cycle; Branch/Zero/Jump valid
Branch  in  1  branch instruction, from decoder
Zero  in  1  ALU zero flag
Jump  in  1  jump instruction, from decoder
pc  out  32  address of current instruction
pc_plus4  out  32  pc + 4, mod 2^32
fetch_err  out  1  sticky ack-timeout error
retired_count  out  32  retired instruction count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, fetch_err=0, timeout counter=0, retired_count=0.
- States: IDLE, FETCH, HOLD, ERROR.
- IDLE: one cycle after reset release, outputs inactive; -> FETCH. An imem_ack arriving in IDLE is ignored.
- FETCH: imem_req=1, imem_addr=pc, both stable until ack.
  - On imem_ack: instr<=imem_rdata; -> HOLD; counter cleared. Ack is allowed in the first FETCH cycle, giving 1-cycle minimum latency from req to instr_valid.
  - Without ack: counter increments each cycle. On reaching ACK_TIMEOUT: fetch_err<=1, imem_req drops next cycle, -> ERROR.
- HOLD: instr_valid=1, imem_req=0. instr, OP, Funct, pc stay stable until consumed.
  - On instr_ready=1: pc<=next_pc; -> FETCH.
  - Without instr_ready: remain in HOLD; no new fetch issued.
- ERROR: all requests stop, instr_valid=0, fetch_err=1. Only reset exits.
- next_pc, evaluated only on instr_valid & instr_ready:
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over Branch.
  - else Branch & Zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), mod 2^32.
  - else pc_plus4.
- pc_plus4 is combinational from pc; pc = 32'hFFFF_FFFC gives pc_plus4 = 0 (wrap).
- OP and Funct are combinational slices of instr, so they read 0 after reset.
- Throughput: at best one instruction per 2 cycles (FETCH + HOLD).
- Reset asserted mid-FETCH or mid-HOLD: immediate return to reset values. A pending memory transaction is abandoned and its late ack is ignored.

Optional Feature:
FETCH_RETIRE_COUNT_EN
- Defined: retired_count is a 32-bit counter that increments on every instr_valid & instr_ready, wraps at 2^32, and is cleared by reset.
- Undefined: no counter logic is built and retired_count is tied to 32'h0.

Test Plan:
- Reset release, memory acks in the first FETCH cycle with 32'h0000_0020 (add), instr_ready=1: imem_addr=0; instr_valid high in the cycle after ack; OP=0, Funct=6'h20; next imem_addr=4.
- pc=8, instr=32'h1000_FFFE (beq, imm=-2), Branch=1, Zero=1, consumed: next imem_addr=32'h0000_0004. Same with Zero=0: next imem_addr=32'h0000_000C.
- pc=32'h1000_0000, instr=32'h0800_0040, Jump=1 and Branch=1 and Zero=1 together: Jump wins; next imem_addr=32'h1000_0100.
- instr_ready held 0 for 5 cycles in HOLD: instr stable, imem_req=0 throughout; on ready, exactly one new request issued.
- No ack for ACK_TIMEOUT=15 cycles: fetch_err=1, state ERROR, imem_req=0 permanently; rst_n pulse clears fetch_err and fetch restarts at RESET_PC.
- Macro defined, 10 instructions consumed: retired_count=10. rst_n asserted mid-FETCH and a late ack arrives during IDLE: instr remains 0 and pc=RESET_PC.
